// File: rtl/mac_pipe_param.sv
// Parametrised pipelined signed multiply-accumulate with per-sample clear.
// Overflow either clamps to the rails or wraps, flagged on sat_out.
module mac_pipe_param #(
  parameter int IN_W        = 14,
  parameter int ACC_W       = 28,
  parameter int MULT_STAGES = 0,
  parameter int SATURATE    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  input  logic                    clear_in,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    sat_out
);

  localparam int PW = 2 * IN_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < PW) begin : g_bad_acc
    $error("mac_pipe_param: ACC_W must be >= 2*IN_W");
  end
  if (MULT_STAGES < 0 || MULT_STAGES > 3) begin : g_bad_stages
    $error("mac_pipe_param: MULT_STAGES must be 0..3");
  end

  typedef struct packed {
    logic                 valid;
    logic                 clear;
    logic signed [PW-1:0] p;
  } prod_t;

  logic signed [IN_W-1:0] a_q;
  logic signed [IN_W-1:0] b_q;
  logic                   v_q;
  logic                   c_q;

  // pipe[0] is the product register, the rest are extra delay stages
  prod_t pipe [MULT_STAGES+1];
  prod_t last;

  logic signed [ACC_W:0]   f_ext;
  logic signed [ACC_W:0]   p_ext;
  logic signed [ACC_W:0]   sum;
  logic                    ovf;
  logic                    do_idle;
  logic                    do_clr;
  logic                    do_ovf;
  logic                    do_acc;
  logic signed [ACC_W-1:0] f_nxt;
  logic                    sat_nxt;
  logic                    valid_nxt;

  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    pipe[0].p <= PW'(a_q) * PW'(b_q);
    for (int i = 1; i <= MULT_STAGES; i++) begin
      pipe[i].p <= pipe[i-1].p;
    end
    if (reset) begin
      v_q <= 1'b0;
      c_q <= 1'b0;
      for (int i = 0; i <= MULT_STAGES; i++) begin
        pipe[i].valid <= 1'b0;
        pipe[i].clear <= 1'b0;
      end
      f         <= '0;
      valid_out <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      v_q <= valid_in;
      c_q <= valid_in & clear_in;
      pipe[0].valid <= v_q;
      pipe[0].clear <= c_q;
      for (int i = 1; i <= MULT_STAGES; i++) begin
        pipe[i].valid <= pipe[i-1].valid;
        pipe[i].clear <= pipe[i-1].clear;
      end
      f         <= f_nxt;
      valid_out <= valid_nxt;
      sat_out   <= sat_nxt;
    end
  end

  assign last  = pipe[MULT_STAGES];
  assign f_ext = (ACC_W+1)'(f);
  assign p_ext = (ACC_W+1)'($signed(last.p));
  assign sum   = f_ext + p_ext;
  assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];

  assign do_idle = ~last.valid;
  assign do_clr  = last.valid & last.clear;
  assign do_ovf  = last.valid & ~last.clear & ovf;
  assign do_acc  = last.valid & ~last.clear & ~ovf;

  always_comb begin
    f_nxt     = f;
    sat_nxt   = 1'b0;
    valid_nxt = last.valid;
    unique case (1'b1)
      do_idle: begin
        f_nxt = f;
      end
      do_clr: begin
        f_nxt = ACC_W'($signed(last.p));
      end
      do_ovf: begin
        sat_nxt = 1'b1;
        if (SATURATE != 0) begin
          f_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
          f_nxt = sum[ACC_W-1:0];
        end
      end
      do_acc: begin
        f_nxt = sum[ACC_W-1:0];
      end
      default: begin
        f_nxt = f;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_pipe_param.sv
// Bench for mac_pipe_param: three configurations share one stimulus
// stream and are checked every cycle against a cycle-indexed model.
module tb_mac_pipe_param;

  localparam int IN_W  = 14;
  localparam int ACC_W = 28;
  localparam longint AMAX = (64'sd1 <<< 27) - 1;
  localparam longint AMIN = -(64'sd1 <<< 27);
  localparam longint AMOD = 64'sd1 <<< 28;
  localparam int HN = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic clear_in = 1'b0;
  logic signed [IN_W-1:0] a = '0;
  logic signed [IN_W-1:0] b = '0;

  logic signed [ACC_W-1:0] f0, f2, fw;
  logic v0, v2, vw, s0, s2, sw;

  mac_pipe_param u0 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .valid_in(valid_in), .clear_in(clear_in),
    .f(f0), .valid_out(v0), .sat_out(s0)
  );

  mac_pipe_param #(.MULT_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .valid_in(valid_in), .clear_in(clear_in),
    .f(f2), .valid_out(v2), .sat_out(s2)
  );

  mac_pipe_param #(.MULT_STAGES(1), .SATURATE(0)) uw (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .valid_in(valid_in), .clear_in(clear_in),
    .f(fw), .valid_out(vw), .sat_out(sw)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int  lat [3] = '{2, 4, 3};
  bit  smode [3] = '{1'b1, 1'b1, 1'b0};

  int  ha [HN];
  int  hb [HN];
  bit  hv [HN];
  bit  hc [HN];
  int  cyc = 0;
  int  last_rst = -100;
  bit  chk_on = 1'b0;

  longint ef [3];
  bit     ev [3];
  bit     es [3];

  typedef struct {
    longint f;
    bit     s;
    int     c;
  } obs_t;

  obs_t o0 [$];
  obs_t o2 [$];
  obs_t ow [$];

  function automatic longint wrap(input longint s);
    longint w;
    w = s & (AMOD - 1);
    if (w > AMAX) w = w - AMOD;
    return w;
  endfunction

  // Output at edge n comes from the sample captured at edge n-lat,
  // provided no reset edge occurred at or after that capture.
  always @(posedge clk) begin
    int m;
    longint p, s;
    ha[cyc] = a;
    hb[cyc] = b;
    hv[cyc] = valid_in;
    hc[cyc] = clear_in;
    for (int k = 0; k < 3; k++) begin
      ev[k] = 1'b0;
      es[k] = 1'b0;
      if (reset) begin
        ef[k] = 0;
      end else begin
        m = cyc - lat[k];
        if (m >= 0 && hv[m] && m > last_rst) begin
          p = longint'(ha[m]) * longint'(hb[m]);
          ev[k] = 1'b1;
          if (hc[m]) begin
            ef[k] = p;
          end else begin
            s = ef[k] + p;
            if (s > AMAX || s < AMIN) begin
              es[k] = 1'b1;
              if (smode[k]) ef[k] = (s > AMAX) ? AMAX : AMIN;
              else ef[k] = wrap(s);
            end else begin
              ef[k] = s;
            end
          end
        end
      end
    end
    if (reset) begin
      last_rst = cyc;
      chk_on = 1'b1;
    end
    cyc++;
  end

  task automatic cmp(input string nm, input int k,
                     input logic signed [ACC_W-1:0] fa,
                     input logic va, input logic sa);
    checks++;
    if (fa !== ACC_W'(ef[k]) || va !== ev[k] || sa !== es[k]) begin
      errors++;
      $display("FAIL %s cyc=%0d: f=%0d v=%b s=%b, want f=%0d v=%b s=%b",
               nm, cyc - 1, fa, va, sa, ef[k], ev[k], es[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("u0", 0, f0, v0, s0);
      cmp("u2", 1, f2, v2, s2);
      cmp("uw", 2, fw, vw, sw);
      if (v0 === 1'b1) o0.push_back('{f: longint'(f0), s: s0, c: cyc - 1});
      if (v2 === 1'b1) o2.push_back('{f: longint'(f2), s: s2, c: cyc - 1});
      if (vw === 1'b1) ow.push_back('{f: longint'(fw), s: sw, c: cyc - 1});
    end
  end

  task automatic lit(input string nm, input obs_t q[$], input int idx,
                     input longint f, input bit s);
    checks++;
    if (idx >= q.size()) begin
      errors++;
      $display("FAIL %s[%0d]: only %0d results, want f=%0d s=%b",
               nm, idx, q.size(), f, s);
    end else if (q[idx].f != f || q[idx].s != s) begin
      errors++;
      $display("FAIL %s[%0d]: f=%0d s=%b, want f=%0d s=%b",
               nm, idx, q[idx].f, q[idx].s, f, s);
    end
  endtask

  task automatic lit_int(input string nm, input longint got,
                         input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input bit v, input bit c, input int aa, input int bb);
    valid_in = v;
    clear_in = c;
    a = IN_W'(aa);
    b = IN_W'(bb);
    tick();
    valid_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    clear_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    clear_in = 1'b0;
    tick();
    reset = 1'b0;
    o0.delete();
    o2.delete();
    ow.delete();
  endtask

  function automatic int pick();
    case ($urandom_range(3))
      0: return -8192;
      1: return 8191;
      default: return int'($urandom_range(16383)) - 8192;
    endcase
  endfunction

  initial begin
    int cap;
    repeat (3) tick();
    reset = 1'b0;
    lit_int("reset_f0", longint'(f0), 0);
    lit_int("reset_v0", longint'(v0), 0);
    lit_int("reset_fw", longint'(fw), 0);

    // latency
    do_reset();
    samp(1'b1, 1'b0, 3, 4);
    cap = cyc - 1;
    idle(8);
    lit_int("lat_n0", o0.size(), 1);
    lit_int("lat_n2", o2.size(), 1);
    lit("lat_u0", o0, 0, 12, 1'b0);
    lit("lat_u2", o2, 0, 12, 1'b0);
    if (o0.size() > 0) lit_int("lat_e0", o0[0].c - cap, 2);
    if (o2.size() > 0) lit_int("lat_e2", o2[0].c - cap, 4);

    // positive saturation, and wrap in uw
    do_reset();
    repeat (4) samp(1'b1, 1'b0, 8191, 8191);
    idle(8);
    lit("pos0", o0, 0, 67092481, 1'b0);
    lit("pos1", o0, 1, 134184962, 1'b0);
    lit("pos2", o0, 2, 134217727, 1'b1);
    lit("pos3", o0, 3, 134217727, 1'b1);
    lit("wrap2", ow, 2, -67158013, 1'b1);

    // negative saturation then recovery
    do_reset();
    repeat (3) samp(1'b1, 1'b0, -8192, 8191);
    samp(1'b1, 1'b0, 1, 1);
    idle(8);
    lit("neg0", o0, 0, -67100672, 1'b0);
    lit("neg1", o0, 1, -134201344, 1'b0);
    lit("neg2", o0, 2, -134217728, 1'b1);
    lit("neg3", o0, 3, -134217727, 1'b0);

    // clear and bubbles, including clear_in without valid_in
    do_reset();
    samp(1'b1, 1'b0, 3, 4);
    samp(1'b0, 1'b1, 9, 9);
    samp(1'b0, 1'b1, 9, 9);
    samp(1'b1, 1'b1, 5, -2);
    samp(1'b1, 1'b0, 1, 1);
    idle(8);
    lit_int("clr_n", o0.size(), 3);
    lit("clr0", o0, 0, 12, 1'b0);
    lit("clr1", o0, 1, -10, 1'b0);
    lit("clr2", o0, 2, -9, 1'b0);

    // reset mid-operation
    do_reset();
    samp(1'b1, 1'b0, 7, 7);
    samp(1'b1, 1'b0, 9, 9);
    reset = 1'b1;
    valid_in = 1'b1;
    a = 14'sd5;
    b = 14'sd5;
    tick();
    reset = 1'b0;
    lit_int("mid_f0", longint'(f0), 0);
    lit_int("mid_v0", longint'(v0), 0);
    samp(1'b1, 1'b0, 2, 2);
    idle(8);
    lit_int("mid_n0", o0.size(), 1);
    lit_int("mid_n2", o2.size(), 1);
    lit("mid0", o0, 0, 4, 1'b0);
    lit("mid2", o2, 0, 4, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) == 0);
      valid_in = ($urandom_range(3) != 0);
      clear_in = ($urandom_range(9) == 0);
      a = IN_W'(pick());
      b = IN_W'(pick());
      tick();
    end
    reset = 1'b0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
- Parametrised, pipelined, signed multiply-accumulate unit. It is the successor to the fixed 14-bit/28-bit saturating MAC.
- Widths and multiplier pipeline depth are configurable. Overflow mode is selectable: saturate or wrap.
- Adds a per-sample accumulator clear, so that back-to-back dot products run without reset.
- Adds a per-result saturation indicator.
- Sits in the datapath between the sample source and the result consumer. There is no backpressure; every valid input produces exactly one valid output.

Parameters:
- IN_W, 14, width of signed operands a and b.
- ACC_W, 28, width of signed accumulator/output f; must satisfy ACC_W >= 2*IN_W (elaboration error otherwise).
- MULT_STAGES, 0, extra product register stages (0..3) inserted after the product register.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- a  input  IN_W  signed multiplicand.
- b  input  IN_W  signed multiplier.
- valid_in  input  1  a/b/clear_in qualify this cycle.
- clear_in  input  1  sample starts a new accumulation (acc := product); ignored when valid_in=0.
- f  output  ACC_W  signed accumulator value.
- valid_out  output  1  f holds a newly accumulated result this cycle.
- sat_out  output  1  this result was clamped (SATURATE=1) or wrapped (SATURATE=0); qualified by valid_out.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: f=0, valid_out=0, sat_out=0. All internal valid/clear pipeline bits are 0.
  - Samples in flight when reset is asserted are discarded.
  - The first post-reset sample accumulates onto 0.
- Pipeline, with E0 = the capture edge:
  - Stage 1 (edge E0): a, b, valid_in, clear_in are registered.
  - Stage 2 (E0+1): product p = a*b, full 2*IN_W signed, is registered.
  - Stages 3..2+MULT_STAGES: p and its valid/clear bits are delayed.
  - Accumulate stage (edge E0+2+MULT_STAGES): f, valid_out and sat_out are updated.
  - Latency from the capture edge to f/valid_out = 2+MULT_STAGES edges. Throughput is one sample per cycle.
- Accumulate when the sample is valid and its clear bit is 0:
  - s = f + sext(p), computed in ACC_W+1 bits.
  - Overflow condition: s > 2^(ACC_W-1)-1 or s < -2^(ACC_W-1).
  - SATURATE=1: f := max positive 2^(ACC_W-1)-1, or min negative -2^(ACC_W-1). sat_out=1.
  - SATURATE=0: f := s[ACC_W-1:0], wrapped. sat_out=1.
  - No overflow: f := s, sat_out=0.
- Clear when the sample is valid and its clear bit is 1:
  - f := sext(p). This never overflows because ACC_W >= 2*IN_W, so sat_out=0.
- Bubble (sample valid bit 0 at the accumulate stage):
  - f holds its value. valid_out=0, sat_out=0.
  - clear_in is ignored when valid_in=0.
- Saturated accumulator: further same-sign products keep f clamped with sat_out=1. An opposite-sign product moves f off the rail normally.
- Extreme product: -2^(IN_W-1) * -2^(IN_W-1) = 2^(2*IN_W-2). This fits in ACC_W and needs no special case.
- valid_out is a single-cycle pulse per valid sample; consecutive valid samples give consecutive pulses.
- f changes only on an accumulate-stage valid sample or on reset.

Test Plan:
- Latency: reset, then a=3, b=4, valid_in=1 for one cycle.
  - MULT_STAGES=0: f=12 with valid_out=1 exactly 2 edges after capture.
  - MULT_STAGES=2: the same result at 4 edges after capture. valid_out=0 on all other cycles.
- Positive saturation (defaults): a=b=8191 for 3 consecutive valid cycles.
  - f = 67092481, then 134184962 (sat_out=0), then 134217727 with sat_out=1.
  - A 4th identical sample keeps f=134217727 with sat_out=1.
- Negative saturation: a=-8192, b=8191 for 3 cycles.
  - f = -67100672, then -134201344, then -134217728 with sat_out=1.
  - Next a=1, b=1 gives f=-134217727 with sat_out=0.
- Wrap mode (SATURATE=0): a=b=8191 for 3 cycles.
  - Third result f = -67158013 with sat_out=1.
- Clear and bubbles: sample (3,4,clear=0), then 2 idle cycles, then sample (5,-2,clear=1), then sample (1,1,clear=0).
  - Results: f=12, then f=-10, then f=-9.
  - f holds 12 with valid_out=0 during the idle cycles.
  - Also drive clear_in=1 with valid_in=0: no effect.
- Reset mid-operation: 4 back-to-back valid samples, with reset asserted for 1 cycle after the 2nd capture.
  - Next edge: f=0, valid_out=0.
  - In-flight samples 1-2 produce no outputs.
  - The next sample (2,2) gives f=4.
